// File: rtl/term_pkg.sv
// rtl/term_pkg.sv - shared constants, control codes and state encoding for term_writer
package term_pkg;

    localparam int COLS         = 132;
    localparam int ROWS         = 30;
    localparam int SCREEN_CELLS = COLS * ROWS;

    localparam logic [7:0] DEF_ATTR   = 8'h70;
    localparam logic [7:0] BLANK_CHAR = 8'h20;

    localparam logic [7:0] CH_BS  = 8'h08;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_FF  = 8'h0C;
    localparam logic [7:0] CH_CR  = 8'h0D;
    localparam logic [7:0] CH_ESC = 8'h1B;

    localparam logic [11:0] ROW_STRIDE    = 12'(COLS);
    localparam logic [11:0] LAST_CELL     = 12'(SCREEN_CELLS - 1);
    localparam logic [11:0] LAST_ROW_BASE = 12'(SCREEN_CELLS - COLS);
    localparam logic [7:0]  LAST_COL      = 8'(COLS - 1);
    localparam logic [4:0]  LAST_ROW      = 5'(ROWS - 1);

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_PUT,
        ST_ESC,
        ST_SCR_RD,
        ST_SCR_WR,
        ST_SCR_CLR
    } state_t;

    // Bytes that land in RAM as glyphs; everything else is a control code or ignored.
    function automatic logic is_printable(input logic [7:0] c);
        return (c >= 8'h20) && (c != 8'h7F);
    endfunction

endpackage

// File: rtl/term_writer.sv
// rtl/term_writer.sv - byte-stream interpreter that writes the 132x30 text screen RAM
module term_writer
    import term_pkg::*;
(
    input  logic        mclk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [11:0] maddr,
    output logic [15:0] wr_data,
    input  logic [15:0] rd_data,
    output logic        mwe,
    output logic        busy,
    output logic [7:0]  cur_col,
    output logic [4:0]  cur_row
);

    // The state names the action that is issued onto the memory port at the
    // next clock edge; every port value is held in a register.
    state_t      state, state_n;
    logic [11:0] cnt, cnt_n;
    logic [11:0] row_base, row_base_n;
    logic [7:0]  attr, attr_n;
    logic [7:0]  col_n;
    logic [4:0]  row_n;
    logic [15:0] wr_q, wr_q_n;
    logic        fwd, fwd_n;
    logic [11:0] maddr_n;
    logic        mwe_n, busy_n, in_ready_n;
    logic        accept, line_feed;

    assign accept = in_valid && in_ready;

    // Scroll copies take the display's registered read port straight back out as
    // write data, so each cell needs only a read cycle and a write cycle.
    assign wr_data = fwd ? rd_data : wr_q;

    // State register.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_n;
        end
    end

    // Cursor, attribute, counters and the registered memory/handshake outputs.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            row_base <= '0;
            attr     <= DEF_ATTR;
            cur_col  <= '0;
            cur_row  <= '0;
            wr_q     <= '0;
            fwd      <= 1'b0;
            maddr    <= '0;
            mwe      <= 1'b0;
            busy     <= 1'b1;
            in_ready <= 1'b0;
        end else begin
            cnt      <= cnt_n;
            row_base <= row_base_n;
            attr     <= attr_n;
            cur_col  <= col_n;
            cur_row  <= row_n;
            wr_q     <= wr_q_n;
            fwd      <= fwd_n;
            maddr    <= maddr_n;
            mwe      <= mwe_n;
            busy     <= busy_n;
            in_ready <= in_ready_n;
        end
    end

    // Next-state and next-output decode; a line feed is resolved after the case
    // because both LF and a wrapping PUT reach it.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        row_base_n = row_base;
        attr_n     = attr;
        col_n      = cur_col;
        row_n      = cur_row;
        wr_q_n     = wr_q;
        fwd_n      = 1'b0;
        maddr_n    = maddr;
        mwe_n      = 1'b0;
        busy_n     = 1'b0;
        in_ready_n = 1'b0;
        line_feed  = 1'b0;

        case (state)
            ST_CLEAR: begin
                maddr_n = cnt;
                wr_q_n  = {attr, BLANK_CHAR};
                mwe_n   = 1'b1;
                busy_n  = 1'b1;
                if (cnt == LAST_CELL) begin
                    state_n    = ST_IDLE;
                    col_n      = '0;
                    row_n      = '0;
                    row_base_n = '0;
                end else begin
                    cnt_n = cnt + 12'd1;
                end
            end

            ST_IDLE: begin
                in_ready_n = 1'b1;
                if (accept) begin
                    if (is_printable(in_data)) begin
                        maddr_n    = row_base + {4'd0, cur_col};
                        wr_q_n     = {attr, in_data};
                        mwe_n      = 1'b1;
                        in_ready_n = 1'b0;
                        state_n    = ST_PUT;
                    end else begin
                        case (in_data)
                            CH_CR:  col_n = '0;
                            CH_LF:  line_feed = 1'b1;
                            CH_BS: begin
                                if (cur_col != 8'd0) col_n = cur_col - 8'd1;
                            end
                            CH_FF: begin
                                state_n    = ST_CLEAR;
                                cnt_n      = '0;
                                in_ready_n = 1'b0;
                                busy_n     = 1'b1;
                            end
                            CH_ESC: state_n = ST_ESC;
                            default: ;
                        endcase
                    end
                end
            end

            ST_PUT: begin
                in_ready_n = 1'b1;
                state_n    = ST_IDLE;
                if (cur_col == LAST_COL) begin
                    col_n     = '0;
                    line_feed = 1'b1;
                end else begin
                    col_n = cur_col + 8'd1;
                end
            end

            ST_ESC: begin
                in_ready_n = 1'b1;
                if (accept) begin
                    attr_n  = in_data;
                    state_n = ST_IDLE;
                end
            end

            ST_SCR_RD: begin
                maddr_n = cnt;
                busy_n  = 1'b1;
                state_n = ST_SCR_WR;
            end

            ST_SCR_WR: begin
                maddr_n = cnt - ROW_STRIDE;
                mwe_n   = 1'b1;
                fwd_n   = 1'b1;
                busy_n  = 1'b1;
                if (cnt == LAST_CELL) begin
                    cnt_n   = LAST_ROW_BASE;
                    state_n = ST_SCR_CLR;
                end else begin
                    cnt_n   = cnt + 12'd1;
                    state_n = ST_SCR_RD;
                end
            end

            ST_SCR_CLR: begin
                maddr_n = cnt;
                wr_q_n  = {attr, BLANK_CHAR};
                mwe_n   = 1'b1;
                busy_n  = 1'b1;
                if (cnt == LAST_CELL) begin
                    state_n = ST_IDLE;
                end else begin
                    cnt_n = cnt + 12'd1;
                end
            end

            default: begin
                state_n = ST_CLEAR;
                cnt_n   = '0;
                busy_n  = 1'b1;
            end
        endcase

        // Moving down a row is a pure pointer update; on the bottom row the
        // first scroll read is issued right away so no cycle is lost.
        if (line_feed) begin
            if (cur_row != LAST_ROW) begin
                row_n      = cur_row + 5'd1;
                row_base_n = row_base + ROW_STRIDE;
            end else begin
                state_n    = ST_SCR_WR;
                cnt_n      = ROW_STRIDE;
                maddr_n    = ROW_STRIDE;
                mwe_n      = 1'b0;
                busy_n     = 1'b1;
                in_ready_n = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_term_writer.sv
// tb/tb_term_writer.sv - directed self-checking bench for term_writer
module tb_term_writer;

    logic        mclk = 1'b0;
    logic        rst;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] maddr;
    logic [15:0] wr_data;
    logic [15:0] rd_data;
    logic        mwe;
    logic        busy;
    logic [7:0]  cur_col;
    logic [4:0]  cur_row;

    logic [15:0] mem [0:4095];
    logic        preload = 1'b0;
    logic        oob = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 mclk = ~mclk;

    term_writer dut (
        .mclk     (mclk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .maddr    (maddr),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .mwe      (mwe),
        .busy     (busy),
        .cur_col  (cur_col),
        .cur_row  (cur_row)
    );

    function automatic logic [15:0] pat(input int a);
        return 16'(a) ^ 16'hA500;
    endfunction

    function automatic logic [7:0] glyph(input int i);
        return 8'(8'h61 + (i % 26));
    endfunction

    // Screen RAM model: synchronous write, registered read.
    always @(posedge mclk) begin
        if (preload) begin
            for (int a = 0; a < 4096; a++) mem[a] <= pat(a);
        end else if (mwe) begin
            mem[maddr] <= wr_data;
        end
        if (mwe && maddr >= 12'd3960) oob <= 1'b1;
        rd_data <= mem[maddr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge right after acceptance.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 20000) begin
            @(negedge mclk);
            n++;
        end
        check("send_ready", in_ready, 1'b1);
        @(negedge mclk);
        in_valid = 1'b0;
    endtask

    task automatic count_not_ready(output int n);
        n = 0;
        while (!in_ready && n < 20000) begin
            n++;
            @(negedge mclk);
        end
    endtask

    task automatic observe_clear(input logic [15:0] fill, input string tag);
        int writes, bad, guard;
        writes = 0;
        bad    = 0;
        guard  = 0;
        while (!in_ready && guard < 6000) begin
            @(negedge mclk);
            guard++;
            if (mwe) begin
                if (maddr !== 12'(writes) || wr_data !== fill || busy !== 1'b1) bad++;
                writes++;
            end
        end
        check({tag, "_writes"}, writes, 3960);
        check({tag, "_cells"}, bad, 0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_cursor"}, {cur_row, cur_col}, 13'd0);
    endtask

    initial begin
        int n;
        int bad;
        logic [15:0] e;

        rst = 1'b1;
        repeat (3) @(negedge mclk);
        check("rst_mwe", mwe, 1'b0);
        check("rst_busy", busy, 1'b1);
        check("rst_ready", in_ready, 1'b0);
        check("rst_maddr", maddr, 12'd0);
        check("rst_wr_data", wr_data, 16'h0000);
        check("rst_cursor", {cur_row, cur_col}, 13'd0);
        rst = 1'b0;
        observe_clear(16'h7020, "clear");

        send_byte(8'h41);
        check("put_a", {mwe, maddr, wr_data}, {1'b1, 12'd0, 16'h7041});
        send_byte(8'h42);
        check("put_b", {mwe, maddr, wr_data}, {1'b1, 12'd1, 16'h7042});
        @(negedge mclk);
        check("col_after_ab", cur_col, 8'd2);

        send_byte(8'h0D);
        check("cr_col", cur_col, 8'd0);
        check("cr_no_write", mwe, 1'b0);
        send_byte(8'h0A);
        check("lf_row", {cur_row, cur_col}, {5'd1, 8'd0});
        send_byte(8'h1B);
        send_byte(8'h1F);
        check("attr_no_write", mwe, 1'b0);
        send_byte(8'h58);
        check("esc_put", {mwe, maddr, wr_data}, {1'b1, 12'd132, 16'h1F58});
        @(negedge mclk);
        check("esc_cursor", {cur_row, cur_col}, {5'd1, 8'd1});

        send_byte(8'h01);
        check("ctl_ignored", {mwe, cur_row, cur_col}, {1'b0, 5'd1, 8'd1});
        send_byte(8'h08);
        check("bs_col", cur_col, 8'd0);
        send_byte(8'h08);
        check("bs_col0", {cur_row, cur_col}, {5'd1, 8'd0});

        for (int i = 0; i < 28; i++) send_byte(8'h0A);
        check("row_bottom", cur_row, 5'd29);

        @(negedge mclk);
        preload = 1'b1;
        @(negedge mclk);
        preload = 1'b0;
        send_byte(8'h0A);
        check("scroll_busy", busy, 1'b1);
        count_not_ready(n);
        check("scroll_ready_low", n, 7788);
        bad = 0;
        for (int a = 0; a < 4096; a++) begin
            if (a < 3828) e = pat(a + 132);
            else if (a < 3960) e = 16'h1F20;
            else e = pat(a);
            if (mem[a] !== e) bad++;
        end
        check("scroll_mem", bad, 0);
        check("scroll_cell0", mem[0], pat(132));
        check("scroll_cell3827", mem[3827], pat(3959));
        check("scroll_cell3828", mem[3828], 16'h1F20);
        check("scroll_cursor", {cur_row, cur_col}, {5'd29, 8'd0});

        for (int i = 0; i < 132; i++) send_byte(glyph(i));
        check("wrap_last_put", {mwe, maddr, wr_data}, {1'b1, 12'd3959, 8'h1F, 8'h62});
        count_not_ready(n);
        check("wrap_ready_low", n, 7789);
        bad = 0;
        for (int a = 3696; a < 3960; a++) begin
            if (a < 3828) e = {8'h1F, glyph(a - 3696)};
            else e = 16'h1F20;
            if (mem[a] !== e) bad++;
        end
        check("wrap_rows", bad, 0);
        check("wrap_cursor", {cur_row, cur_col}, {5'd29, 8'd0});
        send_byte(8'h08);
        check("wrap_bs_col0", {cur_row, cur_col}, {5'd29, 8'd0});

        send_byte(8'h0C);
        observe_clear(16'h1F20, "ff");
        send_byte(8'h5A);
        check("ff_keeps_attr", {mwe, maddr, wr_data}, {1'b1, 12'd0, 16'h1F5A});

        for (int i = 0; i < 29; i++) send_byte(8'h0A);
        check("row_bottom2", cur_row, 5'd29);
        send_byte(8'h0A);
        repeat (999) @(negedge mclk);
        check("pre_rst_mwe", mwe, 1'b1);
        rst = 1'b1;
        #1;
        check("async_mwe", mwe, 1'b0);
        check("async_busy", busy, 1'b1);
        check("async_ready", in_ready, 1'b0);
        repeat (2) @(negedge mclk);
        rst = 1'b0;
        observe_clear(16'h7020, "rst_clear");

        check("never_oob", oob, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
